uart_tx_fifo_cfg: RTL and testbench

Parametrised, FIFO-buffered UART transmitter. It supersedes the fixed 8E1, 115200-baud transmitter used on the 10 MHz tile.

- Frame format and bit period are runtime-configurable.
- Bytes arrive on a valid/ready stream and are queued in an internal FIFO.
- Queued bytes go out back-to-back with no idle gap.
- Sits between the register/command front-end and the `uart_txd` pad.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo_cfg.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo_cfg.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and parity helper for the configurable UART transmitter.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Smallest usable bit period; programmed divisors below this are raised to it.
    localparam int unsigned MIN_DIV = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Parity over the low 5+bits data bits only; upper bits never affect the result.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic [1:0] bits,
                                        input logic [1:0] mode);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5 + int'(bits)) acc ^= data[i];
        end
        return (mode == PAR_ODD) ? ~acc : acc;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic DEPTH x 8 synchronous FIFO with occupancy output.
// Caller guarantees no push when full and no pop when empty.
module uart_sync_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage has no reset; only pointers and level define validity, which keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// FIFO-buffered UART transmitter with runtime frame format and bit period.
// The line, busy and done outputs are registered one cycle behind the FSM state.
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 87
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    input  logic [7:0]                 s_data,
    output logic                       s_ready,
    input  logic [DIV_W-1:0]           cfg_div,
    input  logic [1:0]                 cfg_bits,
    input  logic [1:0]                 cfg_parity,
    input  logic                       cfg_stop2,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       tx_busy,
    output logic                       tx_done,
    output logic                       uart_txd
);
    if (DIV_RESET < int'(MIN_DIV)) begin : g_bad_div_reset
        $error("uart_tx_fifo_cfg: DIV_RESET is below the minimum divisor");
    end

    tx_state_e        state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_clamped;
    logic [7:0]       data_q;
    logic [7:0]       fifo_data;
    logic [2:0]       bit_idx;
    logic [2:0]       last_idx;
    logic             par_en_q;
    logic             par_q;
    logic             stop2_q;
    logic             stop_idx;
    logic             done_pend;
    logic             bit_end;
    logic             last_stop;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             line_bit;

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s_valid && s_ready),
        .push_data (s_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign s_ready     = !fifo_full;
    assign div_clamped = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
    assign bit_end     = (cnt == div_q - DIV_W'(1));
    assign last_stop   = !stop2_q || stop_idx;

    // Popping at the end of the final stop bit lets the next start bit follow with no idle gap.
    assign pop = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end && last_stop));

    always_comb begin
        line_bit = 1'b1;
        case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = data_q[bit_idx];
            PARITY:  line_bit = par_q;
            default: line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            div_q     <= DIV_W'(MIN_DIV);
            data_q    <= '0;
            bit_idx   <= '0;
            last_idx  <= '0;
            par_en_q  <= 1'b0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            stop_idx  <= 1'b0;
            done_pend <= 1'b0;
            tx_done   <= 1'b0;
            tx_busy   <= 1'b0;
            uart_txd  <= 1'b1;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees the pre-edge state.
            uart_txd  <= line_bit;
            tx_busy   <= (state != IDLE);
            tx_done   <= done_pend;
            done_pend <= 1'b0;

            // Frame configuration is frozen at pop; later cfg changes wait for the next frame.
            if (pop) begin
                data_q   <= fifo_data;
                div_q    <= div_clamped;
                last_idx <= 3'd4 + {1'b0, cfg_bits};
                par_en_q <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
                par_q    <= parity_bit(fifo_data, cfg_bits, cfg_parity);
                stop2_q  <= cfg_stop2;
                stop_idx <= 1'b0;
            end

            if (state != IDLE) cnt <= bit_end ? '0 : cnt + DIV_W'(1);

            case (state)
                IDLE: begin
                    if (pop) state <= START;
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == last_idx) state <= par_en_q ? PARITY : STOP;
                        else                     bit_idx <= bit_idx + 3'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) state <= STOP;
                end
                STOP: begin
                    if (bit_end) begin
                        if (!last_stop) begin
                            stop_idx <= 1'b1;
                        end else begin
                            done_pend <= 1'b1;
                            state     <= pop ? START : IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed self-checking bench for uart_tx_fifo_cfg; expected line patterns are hand-written
// as strings of bits in transmission order (start, data LSB first, parity, stop).
module tb_uart_tx_fifo_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic [2:0]  fifo_level;
    logic        tx_busy;
    logic        tx_done;
    logic        uart_txd;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo_cfg #(
        .DEPTH     (4),
        .DIV_W     (16),
        .DIV_RESET (87)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .cfg_div    (cfg_div),
        .cfg_bits   (cfg_bits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .fifo_level (fifo_level),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .uart_txd   (uart_txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the byte is taken at the following rising edge.
    task automatic push(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Entered at the falling edge of frame cycle `skip` (cycle 0 = first start-bit cycle);
    // returns at the falling edge of the tx_done cycle.
    task automatic run_frame(input string tag, input string pat, input int div, input int skip,
                             input int chg_at, input logic [15:0] chg_div, input bit more);
        int c;
        for (int b = 0; b < pat.len(); b++) begin
            for (int k = 0; k < div; k++) begin
                c = b * div + k;
                if (c >= skip) begin
                    if (c == chg_at) cfg_div = chg_div;
                    check($sformatf("%s txd c%0d", tag, c), uart_txd, (pat[b] == "1") ? 1 : 0);
                    check($sformatf("%s busy c%0d", tag, c), tx_busy, 1);
                    if (c != 0) check($sformatf("%s done_early c%0d", tag, c), tx_done, 0);
                    @(negedge clk);
                end
            end
        end
        check({tag, " done_pulse"}, tx_done, 1);
        check({tag, " busy_at_done"}, tx_busy, more);
    endtask

    // After push() returns: level 1, then a pop cycle with the line still idle.
    task automatic expect_launch(input string tag);
        check({tag, " level_after_push"}, fifo_level, 1);
        check({tag, " txd_idle_e0"}, uart_txd, 1);
        @(negedge clk);
        check({tag, " level_after_pop"}, fifo_level, 0);
        check({tag, " txd_idle_e1"}, uart_txd, 1);
        check({tag, " busy_e1"}, tx_busy, 0);
        @(negedge clk);
    endtask

    initial begin
        int seen_done;
        int seen_low;

        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        cfg_div    = 16'd4;
        cfg_bits   = 2'd3;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst txd", uart_txd, 1);
        check("rst busy", tx_busy, 0);
        check("rst done", tx_done, 0);
        check("rst level", fifo_level, 0);
        check("rst ready", s_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, div 4, 0xA5
        push(8'hA5);
        expect_launch("8n1");
        run_frame("8n1", "0101001011", 4, 0, -1, 16'd0, 1'b0);
        @(negedge clk);
        check("8n1 idle_after", uart_txd, 1);
        check("8n1 done_single", tx_done, 0);

        // 7O2, div 4, 0x35
        cfg_bits   = 2'd2;
        cfg_parity = 2'b10;
        cfg_stop2  = 1'b1;
        push(8'h35);
        expect_launch("7o2");
        run_frame("7o2", "01010110111", 4, 0, -1, 16'd0, 1'b0);

        // Five back-to-back 8N1 frames at div 2; FIFO fills during the first one
        cfg_div    = 16'd2;
        cfg_bits   = 2'd3;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        push(8'h00);
        push(8'h3C);
        check("b2b level_full", fifo_level, 4);
        check("b2b ready_low", s_ready, 0);
        run_frame("b2b0", "0100000001", 2, 2, -1, 16'd0, 1'b1);
        check("b2b level_after_pop", fifo_level, 3);
        check("b2b ready_rises", s_ready, 1);
        run_frame("b2b1", "0000000011", 2, 0, -1, 16'd0, 1'b1);
        run_frame("b2b2", "0111111111", 2, 0, -1, 16'd0, 1'b1);
        run_frame("b2b3", "0000000001", 2, 0, -1, 16'd0, 1'b1);
        check("b2b level_last", fifo_level, 0);
        run_frame("b2b4", "0001111001", 2, 0, -1, 16'd0, 1'b0);

        // 8E1: divisor 4 -> 8 changed mid-DATA; second byte already queued
        cfg_div    = 16'd4;
        cfg_parity = 2'b01;
        push(8'h5A);
        push(8'hC3);
        @(negedge clk);
        run_frame("cfg0", "00101101001", 4, 0, 6, 16'd8, 1'b1);
        run_frame("cfg1", "01100001101", 8, 0, -1, 16'd0, 1'b0);

        // Divisor 0 clamps to 2; 5 data bits, even parity over low 5 bits of 0xF3 only
        cfg_div  = 16'd0;
        cfg_bits = 2'd0;
        push(8'hF3);
        expect_launch("clamp");
        run_frame("clamp", "01100111", 2, 0, -1, 16'd0, 1'b0);

        // Reset in the middle of DATA with bytes still queued
        cfg_div    = 16'd4;
        cfg_bits   = 2'd3;
        cfg_parity = 2'b00;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("rstmid start", uart_txd, 0);
        repeat (8) @(negedge clk);
        check("rstmid level_before", fifo_level, 2);
        check("rstmid busy_before", tx_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid txd_async", uart_txd, 1);
        check("rstmid level", fifo_level, 0);
        check("rstmid busy", tx_busy, 0);
        check("rstmid ready", s_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        seen_low  = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx_done === 1'b1) seen_done++;
            if (uart_txd !== 1'b1) seen_low++;
            @(negedge clk);
        end
        check("rstmid no_done", seen_done, 0);
        check("rstmid line_idle", seen_low, 0);
        push(8'h0F);
        expect_launch("rstrec");
        run_frame("rstrec", "0111100001", 4, 0, -1, 16'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
